// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between the chip pads (master side) and the register bank (slave side).
interface spi_reg_bank_if;
   logic cs;
   logic pico;
   logic poci;

   modport master (
      output cs,
      output pico,
      input  poci
   );

   modport slave (
      input  cs,
      input  pico,
      output poci
   );
endinterface

// File: rtl/spi_reg_bank.sv
// Parametrised SPI slave register bank: deserialises frames of {rw, addr[6:0]} followed by
// data bytes, with optional address auto-increment, per-register reset value, implemented-bit
// mask, read-only (status readback) and self-clear-on-idle behaviour.
module spi_reg_bank #(
   parameter int unsigned NUM_REGS = 11,
   parameter logic [8*NUM_REGS-1:0] RST_VALS = {8'h1f, 8'h00, 8'h00, 8'h01, 8'h00, 8'h04,
                                               8'hff, 8'h03, 8'h00, 8'hff, 8'h3f},
   parameter logic [8*NUM_REGS-1:0] REG_MASK   = {NUM_REGS{8'hff}},
   parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
   parameter logic [NUM_REGS-1:0]   PULSE_MASK = 11'b000_0000_0100,
   parameter bit                    BURST_EN   = 1'b1
) (
   input  logic                    spi_clk,
   input  logic                    rst,
   spi_reg_bank_if.slave           spi,
   input  logic [8*NUM_REGS-1:0]   status_in,
   output logic [8*NUM_REGS-1:0]   regs_out,
   output logic [NUM_REGS-1:0]     wr_strobe
);

   localparam logic [8*NUM_REGS-1:0] RST_EFF = RST_VALS & REG_MASK;

   logic [2:0]            bit_cnt_q, bit_cnt_d;
   logic                  first_byte_q, first_byte_d;
   logic [6:0]            sh_in_q, sh_in_d;
   logic                  rw_q, rw_d;
   logic [6:0]            addr_q, addr_d;
   logic [7:0]            rd_shift_q, rd_shift_d;
   logic [8*NUM_REGS-1:0] regs_q, regs_d;
   logic [NUM_REGS-1:0]   strobe_q, strobe_d;

   logic [7:0] rx_byte;
   logic       byte_done;
   logic [6:0] next_addr;

   // Readback for an address: status for RO registers, stored value for RW, zero if unmapped.
   function automatic logic [7:0] rd_val(input logic [6:0]            a,
                                         input logic [8*NUM_REGS-1:0] st,
                                         input logic [8*NUM_REGS-1:0] rg);
      logic [7:0] v;
      v = 8'h00;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         if (a == 7'(i + 1)) begin
            v = RO_MASK[i] ? st[8*i +: 8] : rg[8*i +: 8];
         end
      end
      return v;
   endfunction

   // The current pico bit completes the byte on the 8th edge.
   assign rx_byte   = {sh_in_q, spi.pico};
   assign byte_done = (bit_cnt_q == 3'd7);
   assign next_addr = BURST_EN ? addr_q + 7'd1 : addr_q;

   // Next-state: frame decode, write commit, readback load/shift and idle clearing.
   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      first_byte_d = first_byte_q;
      sh_in_d      = sh_in_q;
      rw_d         = rw_q;
      addr_d       = addr_q;
      rd_shift_d   = rd_shift_q;
      regs_d       = regs_q;
      strobe_d     = '0;

      if (!spi.cs) begin
         // Idle or abort: any partial byte is discarded without commit.
         bit_cnt_d    = 3'd0;
         first_byte_d = 1'b1;
         sh_in_d      = 7'd0;
         rw_d         = 1'b0;
         addr_d       = 7'd0;
         rd_shift_d   = 8'd0;
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (PULSE_MASK[i]) begin
               regs_d[8*i +: 8] = RST_EFF[8*i +: 8];
            end
         end
      end else begin
         bit_cnt_d = bit_cnt_q + 3'd1;
         sh_in_d   = rx_byte[6:0];
         if (byte_done && first_byte_q) begin
            first_byte_d = 1'b0;
            rw_d         = rx_byte[7];
            addr_d       = rx_byte[6:0];
            rd_shift_d   = rd_val(rx_byte[6:0], status_in, regs_q);
         end else if (byte_done) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
               if (rw_q && (addr_q == 7'(i + 1)) && !RO_MASK[i]) begin
                  regs_d[8*i +: 8] = rx_byte & REG_MASK[8*i +: 8];
                  strobe_d[i]      = 1'b1;
               end
            end
            addr_d     = next_addr;
            // Uses pre-commit register contents.
            rd_shift_d = rd_val(next_addr, status_in, regs_q);
         end else if (!first_byte_q) begin
            rd_shift_d = {rd_shift_q[6:0], 1'b0};
         end
      end
   end

   // State registers with synchronous reset taking priority over cs and commits.
   always_ff @(posedge spi_clk) begin
      if (rst) begin
         bit_cnt_q    <= 3'd0;
         first_byte_q <= 1'b1;
         sh_in_q      <= 7'd0;
         rw_q         <= 1'b0;
         addr_q       <= 7'd0;
         rd_shift_q   <= 8'd0;
         regs_q       <= RST_EFF;
         strobe_q     <= '0;
      end else begin
         bit_cnt_q    <= bit_cnt_d;
         first_byte_q <= first_byte_d;
         sh_in_q      <= sh_in_d;
         rw_q         <= rw_d;
         addr_q       <= addr_d;
         rd_shift_q   <= rd_shift_d;
         regs_q       <= regs_d;
         strobe_q     <= strobe_d;
      end
   end

   assign regs_out  = regs_q;
   assign wr_strobe = strobe_q;
   assign spi.poci  = rd_shift_q[7];

endmodule
